instr_dispatcher: RTL and testbench
===================================

Name: instr_dispatcher

Overview:
- Buffers 8-bit host instructions in a FIFO and issues them one at a time to the BRAM-control FSM on its host_instruction input.
- Each instruction is presented for exactly one cycle; the block then drives a no-op until the FSM has accepted and finished it.
- Lets the host push back-to-back instructions (multi-cycle LOAD/UNLOAD included) without polling busy.
- Sits between the host interface and the FSM; the FSM itself is unchanged.

Parameters:
- DEPTH, 8, FIFO entries (power of 2, >=2).
- PTR_W, 3, log2(DEPTH).
- BUSY_TIMEOUT, 4, cycles to wait for fsm_busy to rise after an issue before flagging an error.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_instr  in  8  host instruction: [7:6]=DD, [5:4]=AA, [3:0]=opcode.
- in_valid  in  1  host has an instruction.
- in_ready  out  1  FIFO can accept (not full).
- fsm_busy  in  1  busy output of the FSM.
- fsm_instr  out  8  registered; drives FSM host_instruction.
- done  out  1  one-cycle pulse when an issued instruction completes.
- fifo_count  out  PTR_W+1  current occupancy.
- issued_count  out  16  instructions completed since reset; wraps.
- timeout_err  out  1  sticky; the FSM never went busy after an issue.
- flush  in  1  drop all queued (not yet issued) instructions.

Behaviour:
- Reset (synchronous, reset=1 at an edge): FIFO empty, fifo_count=0, in_ready=1, fsm_instr=8'h00, done=0, issued_count=0, timeout_err=0, state=IDLE.
- NOP encoding: any value with opcode[3:2]=00. 8'h00 is driven whenever nothing is being issued.
- Enqueue: when in_valid && in_ready at an edge, in_instr is written at the write pointer.
  - in_ready = (fifo_count != DEPTH).
  - Writes while full are ignored.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- Enqueued NOP-class instructions are discarded at dequeue in IDLE, one per cycle. They are never issued, raise no done pulse and do not increment issued_count.
- flush: empties the FIFO at the edge and takes priority over a same-cycle enqueue. It does not abort an instruction already in ISSUE/WAIT_BUSY/WAIT_DONE.
- FSM states:
  - IDLE: fsm_instr=00.
    - If the FIFO is non-empty, fsm_busy=0 and the head is not a NOP: pop the head, register it into fsm_instr, go to ISSUE.
    - If the head is a NOP: pop it and stay in IDLE.
  - ISSUE: fsm_instr holds the instruction for exactly this one cycle. Next: fsm_instr=00, timer=0, go to WAIT_BUSY.
  - WAIT_BUSY: fsm_instr=00.
    - fsm_busy=1 goes to WAIT_DONE.
    - Otherwise the timer increments. When timer reaches BUSY_TIMEOUT: set timeout_err, pulse done, go to IDLE.
  - WAIT_DONE: fsm_instr=00. On fsm_busy=0: pulse done for 1 cycle, issued_count+1, go to IDLE.
- Timing: FSM samples the instruction at the ISSUE-cycle edge, and its busy rises one cycle later. WAIT_BUSY therefore sees fsm_busy=1 on its first or second cycle under normal operation.
- Minimum issue-to-issue spacing: ISSUE, WAIT_BUSY(1), WAIT_DONE(>=1), IDLE = 4 cycles for single-cycle ops. LOAD/UNLOAD hold WAIT_DONE for 64 cycles.
- After reset, the FSM spends one cycle busy in its own RESET state. IDLE must see fsm_busy=0 before issuing, so the first issue waits for it.
- timeout_err is cleared only by reset.
- done and issued_count never change in the same cycle as reset.

Test Plan:
- Reset then push 8'h1C (ADD, DD=00, AA=01); hold fsm_busy high 1 cycle post-issue -> fsm_instr=1C for exactly 1 cycle, done pulses, issued_count=1.
- Push 8 instructions back-to-back while fsm_busy=1 -> in_ready drops after the 8th, a 9th write is ignored, fifo_count=8. Release busy -> all 8 issue in order and issued_count=8.
- Push 8'h04 (LOAD) with a model FSM busy for 64 cycles, then 8'h06 -> the second issue appears only after busy falls. No overlap; fsm_instr=00 throughout WAIT_DONE.
- Push 8'h00, 8'h03, 8'h0E -> the NOPs are discarded, only 0E is issued, issued_count=1.
- Issue with fsm_busy tied 0 -> after BUSY_TIMEOUT=4 cycles timeout_err=1 and done pulses. The next instruction still issues.
- Queue 3 instructions, assert flush during WAIT_DONE of the first -> the first completes, fifo_count=0, no further issues. Reset mid-WAIT_DONE -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/instr_dispatcher.sv
// Queues host instructions and hands them to the BRAM-control FSM one at a time,
// holding a no-op on fsm_instr until the FSM has taken and finished each one.
module instr_dispatcher #(
  parameter int DEPTH        = 8,
  parameter int PTR_W        = 3,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_instr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             fsm_busy,
  output logic [7:0]       fsm_instr,
  output logic             done,
  output logic [PTR_W:0]   fifo_count,
  output logic [15:0]      issued_count,
  output logic             timeout_err,
  input  logic             flush
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t           state_q;
  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  logic [7:0]       fsm_instr_q;
  logic             done_q;
  logic [15:0]      issued_q;
  logic             err_q;
  logic [TW-1:0]    timer_q;

  logic [7:0] head;
  logic       head_nop;
  logic       empty;
  logic       push;
  logic       pop;
  logic       issue;

  assign head     = mem_q[rd_ptr_q];
  assign head_nop = (head[3:2] == 2'b00);
  assign empty    = (count_q == '0);
  assign in_ready = (count_q != (PTR_W+1)'(DEPTH));

  // Flush wins over both a same-cycle enqueue and a dequeue of the head.
  assign push  = in_valid && in_ready && !flush;
  assign pop   = (state_q == IDLE) && !empty && !flush && (head_nop || !fsm_busy);
  assign issue = pop && !head_nop;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fsm_instr_q <= 8'h00;
      done_q      <= 1'b0;
      issued_q    <= 16'd0;
      err_q       <= 1'b0;
      timer_q     <= '0;
    end else begin
      done_q <= 1'b0;

      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_d;
      end

      case (state_q)
        IDLE: begin
          fsm_instr_q <= 8'h00;
          if (issue) begin
            fsm_instr_q <= head;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          fsm_instr_q <= 8'h00;
          timer_q     <= '0;
          state_q     <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // The FSM should assert busy within a cycle or two; give up after the limit.
          if (fsm_busy) begin
            state_q <= WAIT_DONE;
          end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!fsm_busy) begin
            done_q   <= 1'b1;
            issued_q <= issued_q + 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fsm_instr    = fsm_instr_q;
  assign done         = done_q;
  assign fifo_count   = count_q;
  assign issued_count = issued_q;
  assign timeout_err  = err_q;

endmodule

// File: tb/tb_instr_dispatcher.sv
// Directed bench for instr_dispatcher with a behavioural model of the BRAM-control FSM.
module tb_instr_dispatcher;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  in_instr = 8'h00;
  logic        in_ready;
  logic        done;
  logic        timeout_err;
  logic [7:0]  fsm_instr;
  logic [3:0]  fifo_count;
  logic [15:0] issued_count;
  logic        fsm_busy;

  // busy_mode: 0 = FSM model, 1 = forced high, 2 = forced low
  int   busy_mode = 0;
  logic model_busy = 1'b0;
  int   rem = 0;

  int compared = 0;
  int failed   = 0;

  int         cyc = 0;
  logic [7:0] log_q[$];
  int         log_cyc[$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         overlap = 0;

  assign fsm_busy = (busy_mode == 1) ? 1'b1 : (busy_mode == 2) ? 1'b0 : model_busy;

  always #5 clk = ~clk;

  instr_dispatcher #(.DEPTH(8), .PTR_W(3), .BUSY_TIMEOUT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_instr     (in_instr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .fsm_busy     (fsm_busy),
    .fsm_instr    (fsm_instr),
    .done         (done),
    .fifo_count   (fifo_count),
    .issued_count (issued_count),
    .timeout_err  (timeout_err),
    .flush        (flush)
  );

  // FSM model: busy one cycle after reset; samples a non-NOP and goes busy next
  // cycle, for 64 cycles on LOAD (4) / UNLOAD (6), otherwise for 1 cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      model_busy <= 1'b1;
      rem        <= 0;
    end else if (fsm_instr[3:2] != 2'b00) begin
      model_busy <= 1'b1;
      rem        <= (fsm_instr[3:0] == 4'h4 || fsm_instr[3:0] == 4'h6) ? 63 : 0;
    end else if (rem != 0) begin
      rem <= rem - 1;
    end else begin
      model_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (fsm_instr != 8'h00) begin
      log_q.push_back(fsm_instr);
      log_cyc.push_back(cyc);
      if (busy_mode == 0 && model_busy) overlap++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  typedef struct {
    logic [7:0] instr;
    int         exp_count;
    int         exp_ready;
  } vec_t;

  vec_t fill_tab[9];

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    in_instr = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_done(input string name, input int target, input int budget);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      tick();
      k++;
    end
    chk(name, done_cnt, target);
  endtask

  function automatic int log_at(input int idx);
    if (idx < log_q.size()) return int'(log_q[idx]);
    return -1;
  endfunction

  function automatic int cyc_at(input int idx);
    if (idx < log_cyc.size()) return log_cyc[idx];
    return -1;
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_fifo_count"}, fifo_count, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_fsm_instr"}, fsm_instr, 8'h00);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_issued_count"}, issued_count, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lb;
    int db;
    int k;

    fill_tab[0] = '{8'h18, 1, 1};
    fill_tab[1] = '{8'h29, 2, 1};
    fill_tab[2] = '{8'h3A, 3, 1};
    fill_tab[3] = '{8'h4B, 4, 1};
    fill_tab[4] = '{8'h5C, 5, 1};
    fill_tab[5] = '{8'h6D, 6, 1};
    fill_tab[6] = '{8'h7E, 7, 1};
    fill_tab[7] = '{8'h8F, 8, 0};
    fill_tab[8] = '{8'h9C, 8, 0};  // write while full is dropped

    // Test 1: reset state and a single ADD
    do_reset();
    check_reset_values("rst");
    lb = log_q.size();
    db = done_cnt;
    push(8'h1C);
    wait_done("t1_done", db + 1, 30);
    repeat (4) tick();
    chk("t1_log_size", log_q.size() - lb, 1);
    chk("t1_instr", log_at(lb), 8'h1C);
    chk("t1_done_pulses", done_cnt - db, 1);
    chk("t1_issued_count", issued_count, 1);
    $display("t1: issued 0x%0h, issued_count=%0d", log_at(lb), issued_count);

    // Test 2: fill while busy, overflow write ignored, then drain in order
    do_reset();
    busy_mode = 1;
    for (int i = 0; i < 9; i++) begin
      push(fill_tab[i].instr);
      chk($sformatf("t2_count_%0d", i), fifo_count, fill_tab[i].exp_count);
      chk($sformatf("t2_ready_%0d", i), in_ready, fill_tab[i].exp_ready);
      $display("t2 push 0x%0h: fifo_count=%0d in_ready=%0d", fill_tab[i].instr, fifo_count, in_ready);
    end
    lb = log_q.size();
    db = done_cnt;
    busy_mode = 0;
    wait_done("t2_done", db + 8, 200);
    repeat (4) tick();
    chk("t2_log_size", log_q.size() - lb, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_order_%0d", i), log_at(lb + i), fill_tab[i].instr);
    end
    chk("t2_issued_count", issued_count, 8);
    chk("t2_fifo_empty", fifo_count, 0);

    // Test 3: LOAD holds the FSM busy for 64 cycles before the next issue
    do_reset();
    lb = log_q.size();
    db = done_cnt;
    overlap = 0;
    push(8'h04);
    push(8'h06);
    wait_done("t3_done", db + 2, 300);
    repeat (4) tick();
    chk("t3_log_size", log_q.size() - lb, 2);
    chk("t3_first", log_at(lb), 8'h04);
    chk("t3_second", log_at(lb + 1), 8'h06);
    chk("t3_spacing", cyc_at(lb + 1) - cyc_at(lb), 67);
    chk("t3_overlap", overlap, 0);
    $display("t3: LOAD at cycle %0d, UNLOAD at cycle %0d", cyc_at(lb), cyc_at(lb + 1));

    // Test 4: NOP-class entries are dropped
    do_reset();
    lb = log_q.size();
    db = done_cnt;
    push(8'h00);
    push(8'h03);
    push(8'h0E);
    wait_done("t4_done", db + 1, 30);
    repeat (6) tick();
    chk("t4_log_size", log_q.size() - lb, 1);
    chk("t4_instr", log_at(lb), 8'h0E);
    chk("t4_done_pulses", done_cnt - db, 1);
    chk("t4_issued_count", issued_count, 1);
    chk("t4_fifo_empty", fifo_count, 0);

    // Test 5: FSM never goes busy -> timeout, then normal issue resumes
    do_reset();
    busy_mode = 2;
    lb = log_q.size();
    db = done_cnt;
    push(8'h1D);
    wait_done("t5_done", db + 1, 30);
    tick();
    chk("t5_timeout_err", timeout_err, 1);
    chk("t5_latency", done_cyc - cyc_at(lb), 5);
    chk("t5_issued_count", issued_count, 0);
    busy_mode = 0;
    push(8'h2E);
    wait_done("t5_after_done", db + 2, 30);
    repeat (2) tick();
    chk("t5_after_instr", log_at(lb + 1), 8'h2E);
    chk("t5_after_issued", issued_count, 1);
    chk("t5_err_sticky", timeout_err, 1);
    $display("t5: timeout_err=%0d issued_count=%0d", timeout_err, issued_count);

    // Test 6: flush during WAIT_DONE keeps the running op, drops the queue
    lb = log_q.size();
    db = done_cnt;
    push(8'h04);
    push(8'h1C);
    push(8'h2D);
    k = 0;
    while (log_q.size() == lb && k < 20) begin
      tick();
      k++;
    end
    repeat (5) tick();
    chk("t6_queued", fifo_count, 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6_flush_count", fifo_count, 0);
    wait_done("t6_done", db + 1, 100);
    repeat (10) tick();
    chk("t6_log_size", log_q.size() - lb, 1);
    chk("t6_instr", log_at(lb), 8'h04);
    chk("t6_issued_count", issued_count, 2);
    chk("t6_done_pulses", done_cnt - db, 1);

    // Reset in the middle of WAIT_DONE
    lb = log_q.size();
    push(8'h04);
    push(8'h1C);
    k = 0;
    while (log_q.size() == lb && k < 20) begin
      tick();
      k++;
    end
    repeat (5) tick();
    chk("t6_pre_reset_count", fifo_count, 1);
    db = done_cnt;
    do_reset();
    check_reset_values("midrst");
    repeat (4) tick();
    chk("midrst_no_done", done_cnt - db, 0);
    chk("midrst_issued", issued_count, 0);
    $display("t6: after mid-op reset fifo_count=%0d issued_count=%0d", fifo_count, issued_count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
